// File: rtl/bitplane_unpack_loader_pkg.sv
// Shared definitions for the bit-plane unpack loader.
// - state_e   : loader FSM states
// - DEF_*     : default image geometry (16-bit words, 1024 words, 128-pixel rows)
// - NUM_PIX   : pixel count of the default image
// - IMG_H     : row count of the default image
// - on_border : true when a (row, col) pixel lies on the outer image frame
package bitplane_unpack_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    LOAD0,
    STREAM,
    FINISH
  } state_e;

  localparam int unsigned DEF_SRC_W     = 16;
  localparam int unsigned DEF_SRC_DEPTH = 1024;
  localparam int unsigned DEF_IMG_W     = 128;
  localparam int unsigned NUM_PIX       = DEF_SRC_DEPTH * DEF_SRC_W;
  localparam int unsigned IMG_H         = NUM_PIX / DEF_IMG_W;

  function automatic logic on_border(input int unsigned row, input int unsigned col,
                                     input int unsigned img_h, input int unsigned img_w);
    return (row == 0) || (row == img_h - 1) || (col == 0) || (col == img_w - 1);
  endfunction

endpackage

// File: rtl/bitplane_unpack_loader_bit_serializer.sv
// bit_serializer: holds one W-bit word and presents it one bit per cycle.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   load       - capture word_in and msb_first, restart at position 0 (wins over advance)
//   advance    - step to the next bit position (wraps W-1 -> 0)
//   msb_first  - 1: bit W-1 is presented first; 0: bit 0 first
//   word_in    - word to serialise
//   cur_bit    - bit at the current position
//   idx        - current position i within the word
module bit_serializer #(
  parameter int unsigned W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 msb_first,
  input  logic [W-1:0]         word_in,
  output logic                 cur_bit,
  output logic [$clog2(W)-1:0] idx
);

  localparam int unsigned        IW       = $clog2(W);
  localparam logic [IW-1:0]      IDX_LAST = IW'(W - 1);

  logic [W-1:0]  buf_q, buf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          msb_q, msb_d;

  // The word is shifted toward the output end, so the current bit is always
  // at a fixed position rather than selected through a wide mux.
  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    msb_d = msb_q;
    if (load) begin
      buf_d = word_in;
      idx_d = '0;
      msb_d = msb_first;
    end else if (advance) begin
      buf_d = msb_q ? {buf_q[W-2:0], 1'b0} : {1'b0, buf_q[W-1:1]};
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q <= '0;
      idx_q <= '0;
      msb_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
      msb_q <= msb_d;
    end
  end

  assign cur_bit = msb_q ? buf_q[W-1] : buf_q[0];
  assign idx     = idx_q;

endmodule

// File: rtl/bitplane_unpack_loader.sv
// bitplane_unpack_loader: streams packed binary-image words from the source
// ROM and writes one pixel per result-RAM location, one write per cycle.
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   start         - pulse to begin a load (ignored unless idle)
//   msb_first     - pixel order within a word, sampled with start
//   clear_border  - force the outer image frame to 0, sampled with start
//   sti_rd/addr   - ROM read strobe / word address; sti_di valid one cycle later
//   res_wr/addr/do- RAM write enable / linear pixel address / pixel value
//   busy, done    - load in progress / level-high completion flag
module bitplane_unpack_loader
  import bitplane_unpack_loader_pkg::*;
#(
  parameter int unsigned SRC_W     = DEF_SRC_W,
  parameter int unsigned SRC_DEPTH = DEF_SRC_DEPTH,
  parameter int unsigned SRC_AW    = $clog2(DEF_SRC_DEPTH),
  parameter int unsigned DST_AW    = $clog2(NUM_PIX),
  parameter int unsigned DST_DW    = 8,
  parameter int unsigned IMG_W     = NUM_PIX / IMG_H,
  parameter int unsigned FG_VAL    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              msb_first,
  input  logic              clear_border,
  output logic              sti_rd,
  output logic [SRC_AW-1:0] sti_addr,
  input  logic [SRC_W-1:0]  sti_di,
  output logic              res_wr,
  output logic [DST_AW-1:0] res_addr,
  output logic [DST_DW-1:0] res_do,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PIX_TOTAL = SRC_DEPTH * SRC_W;
  localparam int unsigned ROWS      = PIX_TOTAL / IMG_W;
  localparam int unsigned IW        = $clog2(SRC_W);
  localparam int unsigned CW        = SRC_AW + 1;

  localparam logic [CW-1:0]     DEPTH_C      = CW'(SRC_DEPTH);
  localparam logic [IW-1:0]     IDX_PREFETCH = IW'(SRC_W - 2);
  localparam logic [IW-1:0]     IDX_LAST     = IW'(SRC_W - 1);
  localparam logic [DST_AW-1:0] ADDR_LAST    = DST_AW'(PIX_TOTAL - 1);
  localparam logic [DST_AW-1:0] COL_LAST     = DST_AW'(IMG_W - 1);
  localparam logic [DST_DW-1:0] FG_C         = DST_DW'(FG_VAL);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                msb_q, msb_d;
  logic                clr_q, clr_d;
  logic                res_wr_q, res_wr_d;
  logic [DST_AW-1:0]   res_addr_q, res_addr_d;
  logic [SRC_AW-1:0]   sti_addr_q, sti_addr_d;
  logic [CW-1:0]       word_cnt_q, word_cnt_d;   // words captured so far this load
  logic [DST_AW-1:0]   col_q, col_d;
  logic [DST_AW-1:0]   row_q, row_d;

  logic                ser_load, ser_adv, ser_bit;
  logic [IW-1:0]       ser_idx;
  logic                more_words;
  logic                border;

  bit_serializer #(.W(SRC_W)) u_ser (
    .clk       (clk),
    .rstn      (rstn),
    .load      (ser_load),
    .advance   (ser_adv),
    .msb_first (msb_q),
    .word_in   (sti_di),
    .cur_bit   (ser_bit),
    .idx       (ser_idx)
  );

  assign more_words = (word_cnt_q < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    msb_d      = msb_q;
    clr_d      = clr_q;
    res_wr_d   = res_wr_q;
    res_addr_d = res_addr_q;
    sti_addr_d = sti_addr_q;
    word_cnt_d = word_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    ser_load   = 1'b0;
    ser_adv    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          msb_d      = msb_first;
          clr_d      = clear_border;
          sti_addr_d = '0;
          word_cnt_d = '0;
          res_addr_d = '0;
          col_d      = '0;
          row_d      = '0;
        end
      end
      FETCH0: state_d = LOAD0;
      LOAD0: begin
        ser_load = 1'b1;
        res_wr_d = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        ser_adv = 1'b1;
        // The prefetched word arrives at the same edge that retires the last
        // bit of the current one, so streaming never stalls.
        if (ser_idx == IDX_LAST && more_words) ser_load = 1'b1;
        if (res_addr_q == ADDR_LAST) begin
          state_d  = FINISH;
          res_wr_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          res_addr_d = res_addr_q + DST_AW'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + DST_AW'(1);
          end else begin
            col_d = col_q + DST_AW'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Each captured word points the ROM address at the next word to fetch;
    // after the final word the address keeps the last issued value.
    if (ser_load) begin
      word_cnt_d = word_cnt_q + CW'(1);
      if (word_cnt_d < DEPTH_C) sti_addr_d = word_cnt_d[SRC_AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      msb_q      <= 1'b0;
      clr_q      <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      sti_addr_q <= '0;
      word_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      msb_q      <= msb_d;
      clr_q      <= clr_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      sti_addr_q <= sti_addr_d;
      word_cnt_q <= word_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign border = on_border(32'(row_q), 32'(col_q), ROWS, IMG_W);

  // Strobe and pixel value are decoded from registered state only, so they
  // line up with the serializer position without an extra pipeline stage.
  assign sti_rd   = (state_q == FETCH0) ||
                    (state_q == STREAM && ser_idx == IDX_PREFETCH && more_words);
  assign sti_addr = sti_addr_q;
  assign res_wr   = res_wr_q;
  assign res_addr = res_addr_q;
  assign res_do   = (res_wr_q && ser_bit && !(clr_q && border)) ? FG_C : '0;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bitplane_unpack_loader.sv
module tb_bitplane_unpack_loader;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic msb_first = 1'b0, clear_border = 1'b0;

  // Default configuration: 16-bit words, 1024 words, 128x128 image, FG=1
  logic        a_sti_rd;
  logic [9:0]  a_sti_addr;
  logic [15:0] a_sti_di = '0;
  logic        a_res_wr;
  logic [13:0] a_res_addr;
  logic [7:0]  a_res_do;
  logic        a_busy, a_done;

  // Small configuration: 8-bit words, 32 words, 16x16 image, FG=FF
  logic        b_sti_rd;
  logic [4:0]  b_sti_addr;
  logic [7:0]  b_sti_di = '0;
  logic        b_res_wr;
  logic [7:0]  b_res_addr;
  logic [7:0]  b_res_do;
  logic        b_busy, b_done;

  logic [15:0] rom_a [1024];
  logic [7:0]  rom_b [32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bitplane_unpack_loader dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .msb_first(msb_first),
    .clear_border(clear_border), .sti_rd(a_sti_rd), .sti_addr(a_sti_addr),
    .sti_di(a_sti_di), .res_wr(a_res_wr), .res_addr(a_res_addr),
    .res_do(a_res_do), .busy(a_busy), .done(a_done)
  );

  bitplane_unpack_loader #(
    .SRC_W(8), .SRC_DEPTH(32), .SRC_AW(5), .DST_AW(8), .DST_DW(8),
    .IMG_W(16), .FG_VAL(8'hFF)
  ) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .msb_first(msb_first),
    .clear_border(clear_border), .sti_rd(b_sti_rd), .sti_addr(b_sti_addr),
    .sti_di(b_sti_di), .res_wr(b_res_wr), .res_addr(b_res_addr),
    .res_do(b_res_do), .busy(b_busy), .done(b_done)
  );

  // Source ROMs: data valid in the cycle after the read strobe
  always @(posedge clk) begin
    if (a_sti_rd) a_sti_di <= rom_a[a_sti_addr];
    if (b_sti_rd) b_sti_di <= rom_b[b_sti_addr];
  end

  // Reference pixel k of a load: word k/W, position k%W, frame by row/col arithmetic
  function automatic int exp_pix(input int sel, input int k, input logic msb, input logic clr);
    int w, iw, h, fg, word, i, bitpos, row, col;
    logic [15:0] wv;
    w  = (sel != 0) ? 8 : 16;
    iw = (sel != 0) ? 16 : 128;
    h  = (sel != 0) ? (8 * 32) / 16 : (16 * 1024) / 128;
    fg = (sel != 0) ? 255 : 1;
    word = k / w;
    i    = k % w;
    wv   = (sel != 0) ? {8'h00, rom_b[word]} : rom_a[word];
    bitpos = msb ? (w - 1 - i) : i;
    row = k / iw;
    col = k % iw;
    if (clr && (row == 0 || row == h - 1 || col == 0 || col == iw - 1)) return 0;
    return wv[bitpos] ? fg : 0;
  endfunction

  // One complete load with cycle-accurate checks; abort_at >= 0 resets mid-stream
  task automatic run_load(input int sel, input logic msb, input logic clr,
                          input int abort_at, output int ones);
    int w, d, np, writes;
    int o_rd, o_saddr, o_wr, o_addr, o_do, o_busy, o_done;
    int e_rd, e_saddr, e_wr, e_busy, e_done, e_do;
    w  = (sel != 0) ? 8 : 16;
    d  = (sel != 0) ? 32 : 1024;
    np = w * d;
    ones = 0;
    writes = 0;
    msb_first = msb;
    clear_border = clr;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int t = 1; t <= np + 5; t++) begin
      if (abort_at >= 0 && t == 3 + abort_at) begin
        rstn = 1'b0;
        #1;
        checks++;
        if ({a_sti_rd, a_sti_addr, a_res_wr, a_res_addr, a_res_do, a_busy, a_done} !== '0) begin
          errors++;
          $display("FAIL abort_outputs t=%0d rd=%0d saddr=%0d wr=%0d addr=%0d do=%0d busy=%0d done=%0d required all 0",
                   t, a_sti_rd, a_sti_addr, a_res_wr, a_res_addr, a_res_do, a_busy, a_done);
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          checks++;
          if (a_sti_rd !== 1'b0 || a_res_wr !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle c=%0d rd=%0d wr=%0d busy=%0d done=%0d required 0 0 0 0",
                     c, a_sti_rd, a_res_wr, a_busy, a_done);
          end
        end
        return;
      end

      o_rd    = (sel != 0) ? int'(b_sti_rd)   : int'(a_sti_rd);
      o_saddr = (sel != 0) ? int'(b_sti_addr) : int'(a_sti_addr);
      o_wr    = (sel != 0) ? int'(b_res_wr)   : int'(a_res_wr);
      o_addr  = (sel != 0) ? int'(b_res_addr) : int'(a_res_addr);
      o_do    = (sel != 0) ? int'(b_res_do)   : int'(a_res_do);
      o_busy  = (sel != 0) ? int'(b_busy)     : int'(a_busy);
      o_done  = (sel != 0) ? int'(b_done)     : int'(a_done);

      e_wr    = (t >= 3 && t < 3 + np) ? 1 : 0;
      e_rd    = (t == 1 || (e_wr == 1 && (t - 3) % w == w - 2 && (t - 3) / w < d - 1)) ? 1 : 0;
      e_saddr = (t == 1) ? 0 : (t - 3) / w + 1;
      e_busy  = (t <= np + 2) ? 1 : 0;
      e_done  = (t >= np + 3) ? 1 : 0;

      checks++;
      if (o_wr !== e_wr) begin
        errors++;
        $display("FAIL res_wr sel=%0d t=%0d got %0d want %0d", sel, t, o_wr, e_wr);
      end
      checks++;
      if (o_rd !== e_rd) begin
        errors++;
        $display("FAIL sti_rd sel=%0d t=%0d got %0d want %0d", sel, t, o_rd, e_rd);
      end
      if (e_rd == 1) begin
        checks++;
        if (o_saddr !== e_saddr) begin
          errors++;
          $display("FAIL sti_addr sel=%0d t=%0d got %0d want %0d", sel, t, o_saddr, e_saddr);
        end
      end
      checks++;
      if (o_busy !== e_busy || o_done !== e_done) begin
        errors++;
        $display("FAIL busy_done sel=%0d t=%0d got %0d/%0d want %0d/%0d",
                 sel, t, o_busy, o_done, e_busy, e_done);
      end
      if (e_wr == 1) begin
        e_do = exp_pix(sel, t - 3, msb, clr);
        checks++;
        if (o_addr !== t - 3 || o_do !== e_do) begin
          errors++;
          $display("FAIL pixel sel=%0d t=%0d got addr %0d val %0h want addr %0d val %0h",
                   sel, t, o_addr, o_do, t - 3, e_do);
        end
      end
      if (o_wr == 1) writes++;
      if (o_wr == 1 && o_do != 0) ones++;

      // start while streaming and start in the FINISH cycle must both be ignored
      if (t == 100 && t < np) begin
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
      end else if (t == np + 3) begin
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    checks++;
    if (writes !== np) begin
      errors++;
      $display("FAIL write_count sel=%0d got %0d want %0d", sel, writes, np);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_sti_rd, a_sti_addr, a_res_wr, a_res_addr, a_res_do, a_busy, a_done,
         b_sti_rd, b_sti_addr, b_res_wr, b_res_addr, b_res_do, b_busy, b_done} !== '0) begin
      errors++;
      $display("FAIL reset_state a: rd=%0d wr=%0d busy=%0d done=%0d b: rd=%0d wr=%0d busy=%0d done=%0d required all 0",
               a_sti_rd, a_res_wr, a_busy, a_done, b_sti_rd, b_res_wr, b_busy, b_done);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    int ones;
    for (int i = 0; i < 1024; i++) rom_a[i] = 16'($urandom);
    rom_a[0] = 16'h8001;
    rom_a[1] = 16'h0003;
    run_load(0, 1'b1, 1'b0, -1, ones);
  endtask

  task automatic test_lsb_first();
    int ones;
    run_load(0, 1'b0, 1'b0, -1, ones);
  endtask

  task automatic test_border();
    int ones;
    for (int i = 0; i < 1024; i++) rom_a[i] = 16'hFFFF;
    run_load(0, 1'($urandom), 1'b1, -1, ones);
    checks++;
    if (ones !== 126 * 126) begin
      errors++;
      $display("FAIL border_interior got %0d set pixels want %0d", ones, 126 * 126);
    end
  endtask

  task automatic test_reset_abort();
    int ones;
    for (int i = 0; i < 1024; i++) rom_a[i] = 16'($urandom);
    run_load(0, 1'($urandom), 1'b0, 5000, ones);
  endtask

  task automatic test_param_sweep();
    int ones;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) rom_b[i] = 8'($urandom);
      run_load(1, r[0], r[1], -1, ones);
    end
    for (int i = 0; i < 32; i++) rom_b[i] = 8'hFF;
    run_load(1, 1'b0, 1'b1, -1, ones);
    checks++;
    if (ones !== 14 * 14) begin
      errors++;
      $display("FAIL sweep_border_interior got %0d set pixels want %0d", ones, 14 * 14);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_a[i] = '0;
    for (int i = 0; i < 32; i++) rom_b[i] = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_border();
    test_reset_abort();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
